// File: rtl/seg_display_driver.sv
// Multi-digit 7-segment driver: captures a binary value, converts it to BCD one bit per
// cycle (double dabble), then commits decoded segment patterns. Optional blink gating: SEG_DISPLAY_BLINK_EN.
module seg_display_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14,
  parameter int ACTIVE_LOW = 1
`ifdef SEG_DISPLAY_BLINK_EN
  , parameter int BLINK_DIV = 25_000_000
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BIN_WIDTH-1:0]    bin_value,
  input  logic                    blank_lz,
`ifdef SEG_DISPLAY_BLINK_EN
  input  logic                    blink,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] segments
);

  localparam int BCD_W   = 4 * NUM_DIGITS + 4;
  localparam int SHIFT_W = BCD_W + BIN_WIDTH;
  localparam int SEG_W   = 7 * NUM_DIGITS;
  localparam int CNT_W   = $clog2(BIN_WIDTH + 1);

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [31:0] MAX_VAL = 32'(pow10(NUM_DIGITS) - 1);

  // Patterns are defined active-low {g..a} and inverted once here for the other polarity.
  localparam logic [6:0] POL_MASK  = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
  localparam logic [6:0] BLANK_PAT = 7'h7F ^ POL_MASK;
  localparam logic [6:0] DASH_PAT  = 7'h3F ^ POL_MASK;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] p;
    case (nib)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p ^ POL_MASK;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 blank_lz_q, blank_lz_d;
  logic                 pend_ovf_q, pend_ovf_d;
  logic                 ovf_q, ovf_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [SHIFT_W-1:0]   adj;
  logic [SEG_W-1:0]     disp_pat;
  logic [3:0]           nib;
  logic                 lz_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      blank_lz_q <= 1'b0;
      pend_ovf_q <= 1'b0;
      ovf_q      <= 1'b0;
      seg_q      <= {NUM_DIGITS{BLANK_PAT}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      blank_lz_q <= blank_lz_d;
      pend_ovf_q <= pend_ovf_d;
      ovf_q      <= ovf_d;
      seg_q      <= seg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Decode the BCD field of the shift register; digits above the leading nonzero one
  // blank when requested, digit 0 always shows.
  always_comb begin
    disp_pat = '0;
    lz_run   = blank_lz_q;
    nib      = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = shift_q[BIN_WIDTH + 4*k +: 4];
      if (pend_ovf_q) begin
        disp_pat[7*k +: 7] = DASH_PAT;
      end else if (lz_run && (nib == 4'd0) && (k != 0)) begin
        disp_pat[7*k +: 7] = BLANK_PAT;
      end else begin
        disp_pat[7*k +: 7] = decode(nib);
        lz_run = 1'b0;
      end
    end
  end

  // Handshake: load is a one-cycle request taken only while busy=0 in IDLE; anything
  // else is dropped. busy covers the whole conversion including the done cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    blank_lz_d = blank_lz_q;
    pend_ovf_d = pend_ovf_q;
    ovf_d      = ovf_q;
    seg_d      = seg_q;
    busy_d     = (state_q != ST_IDLE);
    done_d     = 1'b0;
    adj        = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (load && !busy_q) begin
          shift_d    = {{BCD_W{1'b0}}, bin_value};
          cnt_d      = '0;
          blank_lz_d = blank_lz;
          pend_ovf_d = (32'(bin_value) > MAX_VAL);
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        for (int j = 0; j <= NUM_DIGITS; j++) begin
          if (adj[BIN_WIDTH + 4*j +: 4] >= 4'd5)
            adj[BIN_WIDTH + 4*j +: 4] = adj[BIN_WIDTH + 4*j +: 4] + 4'd3;
        end
        shift_d = {adj[SHIFT_W-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        seg_d   = disp_pat;
        ovf_d   = pend_ovf_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

`ifdef SEG_DISPLAY_BLINK_EN
  localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BCNT_W-1:0] bcnt_q;
  logic              phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (bcnt_q == BCNT_W'(BLINK_DIV - 1)) begin
      bcnt_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      bcnt_q  <= bcnt_q + BCNT_W'(1);
    end
  end

  assign segments = (blink && phase_q) ? {NUM_DIGITS{BLANK_PAT}} : seg_q;
`else
  assign segments = seg_q;
`endif

endmodule
